master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/master_port.sv | 225 ++++++++++++++++++++++
 tb/tb_master_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// master_port: serial bus master. Accepts one host command, runs the
// REQ/ADDR/WDATA or REQ/ADDR/RWAIT/RDATA handshake with a slave over single-bit
// lines, then returns a one-cycle completion response (with timeout error flag).
module master_port #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              read_enable,
  output logic              write_enable,
  output logic              m_valid,
  output logic              m_ready,
  input  logic              s_ready,
  input  logic              s_valid,
  input  logic              split_enable,
  output logic              tx_address,
  output logic              tx_data,
  output logic              tx_burst,
  input  logic              rx_data
);

  localparam int unsigned BIT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned BC_W    = $clog2(BIT_MAX + 1);
  localparam int unsigned TO_W    = 8;

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_W - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_SPLIT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0] wdata_sh_q, wdata_sh_d;
  logic [DATA_W-1:0] rdata_sh_q, rdata_sh_d;
  logic              write_q, write_d;
  logic              err_q, err_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;
  logic              read_en_q, read_en_d;
  logic              write_en_q, write_en_d;
  logic              m_valid_q, m_valid_d;
  logic              m_ready_q, m_ready_d;
  logic              tx_addr_q, tx_addr_d;
  logic              tx_data_q, tx_data_d;
  logic              busy_d;
  logic [DATA_W-1:0] rx_shifted;

  // Read data enters at the MSB so that after DATA_W captures bit 0 sits at the LSB
  assign rx_shifted = (rdata_sh_q >> 1) | (DATA_W'(rx_data) << (DATA_W - 1));

  // Next-state, datapath and look-ahead output decode
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    addr_sh_d  = addr_sh_q;
    wdata_sh_d = wdata_sh_q;
    rdata_sh_d = rdata_sh_q;
    write_d    = write_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d    = S_REQ;
          addr_sh_d  = cmd_address;
          wdata_sh_d = cmd_wdata;
          write_d    = cmd_write;
          rdata_sh_d = '0;
          err_d      = 1'b0;
          to_cnt_d   = '0;
          bit_cnt_d  = '0;
        end
      end
      S_REQ: begin
        if (s_ready) begin
          state_d   = S_ADDR;
          bit_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_ADDR: begin
        addr_sh_d = addr_sh_q >> 1;
        if (bit_cnt_q == ADDR_LAST) begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = write_q ? S_WDATA : S_RWAIT;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      S_WDATA: begin
        wdata_sh_d = wdata_sh_q >> 1;
        if (bit_cnt_q == DATA_LAST) begin
          bit_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      S_RWAIT: begin
        // split wins over a simultaneous s_valid; nothing is captured then
        if (split_enable) begin
          state_d = S_SPLIT;
        end else if (s_valid) begin
          rdata_sh_d = rx_shifted;
          bit_cnt_d  = BC_W'(1);
          state_d    = (DATA_LAST == '0) ? S_DONE : S_RDATA;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_RDATA: begin
        if (s_valid) begin
          rdata_sh_d = rx_shifted;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      S_SPLIT: begin
        // timeout counter is deliberately left untouched while split
        if (!split_enable) state_d = S_RWAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = state_d inside {S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_SPLIT};
    cmd_ready_d = (state_d == S_IDLE);
    m_valid_d   = state_d inside {S_REQ, S_ADDR, S_WDATA};
    m_ready_d   = state_d inside {S_RWAIT, S_RDATA};
    write_en_d  = busy_d & write_d;
    read_en_d   = busy_d & ~write_d;
    tx_addr_d   = (state_d == S_ADDR) & addr_sh_d[0];
    tx_data_d   = (state_d == S_WDATA) & wdata_sh_d[0];
    rsp_valid_d = (state_d == S_DONE);
    rsp_error_d = (state_d == S_DONE) & err_d;
    rsp_rdata_d = ((state_d == S_DONE) && !write_d && !err_d) ? rdata_sh_d : '0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      addr_sh_q   <= '0;
      wdata_sh_q  <= '0;
      rdata_sh_q  <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      read_en_q   <= 1'b0;
      write_en_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_ready_q   <= 1'b0;
      tx_addr_q   <= 1'b0;
      tx_data_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_sh_q   <= addr_sh_d;
      wdata_sh_q  <= wdata_sh_d;
      rdata_sh_q  <= rdata_sh_d;
      write_q     <= write_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      read_en_q   <= read_en_d;
      write_en_q  <= write_en_d;
      m_valid_q   <= m_valid_d;
      m_ready_q   <= m_ready_d;
      tx_addr_q   <= tx_addr_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_error    = rsp_error_q;
  assign read_enable  = read_en_q;
  assign write_enable = write_en_q;
  assign m_valid      = m_valid_q;
  assign m_ready      = m_ready_q;
  assign tx_address   = tx_addr_q;
  assign tx_data      = tx_data_q;
  assign tx_burst     = 1'b0;

endmodule

// File: tb/tb_master_port.sv
// Directed self-checking bench for master_port (default parameters).
module tb_master_port;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_write;
  logic [11:0] cmd_address;
  logic [7:0]  cmd_wdata;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic        read_enable;
  logic        write_enable;
  logic        m_valid;
  logic        m_ready;
  logic        s_ready;
  logic        s_valid;
  logic        split_enable;
  logic        tx_address;
  logic        tx_data;
  logic        tx_burst;
  logic        rx_data;

  int tests;
  int fails;

  master_port #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(63)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_address(cmd_address),
    .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .read_enable(read_enable), .write_enable(write_enable),
    .m_valid(m_valid), .m_ready(m_ready),
    .s_ready(s_ready), .s_valid(s_valid), .split_enable(split_enable),
    .tx_address(tx_address), .tx_data(tx_data), .tx_burst(tx_burst),
    .rx_data(rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full write transfer; s_ready is withheld for dly REQ cycles
  task automatic do_write(input logic [11:0] a, input logic [7:0] d, input int dly);
    chk("wr_idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = a; cmd_wdata = d; s_ready = 1'b0;
    step();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = ~a; cmd_wdata = ~d;
    chk("wr_req_ready", 32'(cmd_ready), 32'd0);
    chk("wr_req_wen", 32'({write_enable, read_enable}), 32'd2);
    for (int i = 0; i < dly; i++) begin
      chk("wr_req_mvalid", 32'({m_valid, m_ready}), 32'd2);
      step();
    end
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("wr_addr_bit", 32'(tx_address), 32'(a[i]));
      chk("wr_addr_mv", 32'({m_valid, m_ready, tx_data}), 32'd4);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      chk("wr_data_bit", 32'(tx_data), 32'(d[i]));
      chk("wr_data_mv", 32'({m_valid, tx_address, tx_burst}), 32'd4);
      step();
    end
    chk("wr_done_valid", 32'(rsp_valid), 32'd1);
    chk("wr_done_err", 32'(rsp_error), 32'd0);
    chk("wr_done_rdata", 32'(rsp_rdata), 32'd0);
    chk("wr_done_ready", 32'(cmd_ready), 32'd0);
    chk("wr_done_lines", 32'({write_enable, m_valid, tx_data}), 32'd0);
    step();
    chk("wr_after_valid", 32'(rsp_valid), 32'd0);
    chk("wr_after_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Full read transfer; optional stall before bit stall_at, optional split of split_n cycles
  task automatic do_read(input logic [11:0] a, input logic [7:0] d, input int stall_at,
                         input int split_n);
    chk("rd_idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = a; cmd_wdata = 8'hFF;
    step();
    cmd_valid = 1'b0; cmd_write = 1'b1; cmd_address = ~a;
    chk("rd_req_en", 32'({write_enable, read_enable}), 32'd1);
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("rd_addr_bit", 32'(tx_address), 32'(a[i]));
      step();
    end
    chk("rd_rwait_hs", 32'({m_valid, m_ready}), 32'd1);
    chk("rd_rwait_ren", 32'(read_enable), 32'd1);
    if (split_n > 0) begin
      split_enable = 1'b1; s_valid = 1'b1; rx_data = 1'b1;
      step();
      chk("rd_split_hs", 32'({m_valid, m_ready}), 32'd0);
      chk("rd_split_ren", 32'(read_enable), 32'd1);
      for (int i = 0; i < split_n - 1; i++) step();
      chk("rd_split_end_hs", 32'({m_ready, rsp_valid}), 32'd0);
      split_enable = 1'b0; s_valid = 1'b0; rx_data = 1'b0;
      step();
      chk("rd_unsplit_hs", 32'({m_valid, m_ready}), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        s_valid = 1'b0; rx_data = ~d[i];
        step();
      end
      chk("rd_bit_hs", 32'({m_valid, m_ready, rsp_valid}), 32'd2);
      s_valid = 1'b1; rx_data = d[i];
      step();
    end
    s_valid = 1'b0; rx_data = 1'b0;
    chk("rd_done_valid", 32'(rsp_valid), 32'd1);
    chk("rd_done_rdata", 32'(rsp_rdata), 32'(d));
    chk("rd_done_err", 32'(rsp_error), 32'd0);
    chk("rd_done_lines", 32'({m_ready, read_enable, cmd_ready}), 32'd0);
    step();
    chk("rd_after_valid", 32'(rsp_valid), 32'd0);
    chk("rd_after_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_wdata = '0;
    s_ready = 1'b0; s_valid = 1'b0; split_enable = 1'b0; rx_data = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outs", 32'({rsp_valid, rsp_rdata, rsp_error, read_enable, write_enable,
                         m_valid, m_ready, tx_address, tx_data, tx_burst}), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    // Write A53/5C with s_ready after two wait cycles
    do_write(12'hA53, 8'h5C, 2);

    // Read 001 returning C3 with a stall before bit 4
    do_read(12'h001, 8'hC3, 4, 0);

    // Read with simultaneous split/s_valid, 100 split cycles, no timeout
    do_read(12'h2B4, 8'hA5, 8, 100);

    // Timeout: s_ready never arrives
    chk("to_idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 12'h123; cmd_wdata = 8'h45;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 62; i++) step();
    chk("to_c62_rsp", 32'({rsp_valid, m_valid}), 32'd1);
    step();
    chk("to_c63_valid", 32'(rsp_valid), 32'd1);
    chk("to_c63_err", 32'(rsp_error), 32'd1);
    chk("to_c63_rdata", 32'(rsp_rdata), 32'd0);
    chk("to_c63_lines", 32'({m_valid, write_enable}), 32'd0);
    step();
    chk("to_after", 32'({rsp_valid, rsp_error, cmd_ready}), 32'd1);

    // Reset in the 5th ADDR cycle
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 12'h0FF; cmd_wdata = 8'hAA;
    step();
    cmd_valid = 1'b0; s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rst5_pre_bit", 32'({tx_address, m_valid}), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst5_ready", 32'(cmd_ready), 32'd1);
    chk("rst5_outs", 32'({rsp_valid, rsp_rdata, rsp_error, read_enable, write_enable,
                          m_valid, m_ready, tx_address, tx_data, tx_burst}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst5_quiet", 32'({rsp_valid, cmd_ready}), 32'd1);
    end
    do_write(12'h5A5, 8'h3C, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
